outputc: RTL and testbench

Output channel of the mesh router: one instance per output physical channel (PORTID 0..4). Arbitrates among the five input channels that request this port, round-robin with per-packet lock. Issues per-cycle grants gated by downstream readiness and forwards the granted input's flits to the link. Exports per-VC ready/lock status back to every input channel's `irdy_*`/`ilck_*`.

---
 rtl/outputc_pkg.sv | 33 +++
 rtl/outputc_rrarb.sv | 28 ++
 rtl/outputc.sv | 154 +++++++++++++++
 tb/tb_outputc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/outputc_pkg.sv
// Shared widths, flit type codes and FSM state type for the router output channel.
package outputc_pkg;

    localparam int DATAW    = 31;
    localparam int VCHW     = 1;
    localparam int VCH      = 3;
    localparam int PORTW    = 2;
    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 30;

    localparam int unsigned NIN  = 5;
    localparam int unsigned PTRW = 3;

    localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_BODY     = 2'b00;
    localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_HEAD     = 2'b01;
    localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_TAIL     = 2'b10;
    localparam logic [TYPE_MSB-TYPE_LSB:0] TYPE_HEADTAIL = 2'b11;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    function automatic logic is_tail(input logic [DATAW:0] flit);
        logic [TYPE_MSB-TYPE_LSB:0] ftype;
        ftype = flit[TYPE_MSB:TYPE_LSB];
        return (ftype == TYPE_TAIL) || (ftype == TYPE_HEADTAIL);
    endfunction

endpackage

// File: rtl/outputc_rrarb.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo 5.
module rrarb
    import outputc_pkg::*;
(
    input  logic [NIN-1:0]  req,
    input  logic [PTRW-1:0] ptr,
    output logic [NIN-1:0]  gnt,
    output logic [PTRW-1:0] winner
);

    always_comb begin
        logic            found;
        logic [PTRW-1:0] idx;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            idx = PTRW'((32'(ptr) + i) % NIN);
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                winner      = idx;
            end
        end
    end

endmodule

// File: rtl/outputc.sv
// Mesh router output channel: round-robin packet-locked switch arbitration and flit forwarding.
// Define OUTC_OREG_EN to register odata/ovalid/ovch (one cycle later); otherwise they are combinational.
module outputc
    import outputc_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PORTID   = 0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             req_0,
    input  logic             req_1,
    input  logic             req_2,
    input  logic             req_3,
    input  logic             req_4,
    input  logic [PORTW:0]   port_0,
    input  logic [PORTW:0]   port_1,
    input  logic [PORTW:0]   port_2,
    input  logic [PORTW:0]   port_3,
    input  logic [PORTW:0]   port_4,
    input  logic [DATAW:0]   idata_0,
    input  logic [DATAW:0]   idata_1,
    input  logic [DATAW:0]   idata_2,
    input  logic [DATAW:0]   idata_3,
    input  logic [DATAW:0]   idata_4,
    input  logic             ivalid_0,
    input  logic             ivalid_1,
    input  logic             ivalid_2,
    input  logic             ivalid_3,
    input  logic             ivalid_4,
    input  logic [VCHW:0]    ivch_0,
    input  logic [VCHW:0]    ivch_1,
    input  logic [VCHW:0]    ivch_2,
    input  logic [VCHW:0]    ivch_3,
    input  logic [VCHW:0]    ivch_4,
    output logic             grt_0,
    output logic             grt_1,
    output logic             grt_2,
    output logic             grt_3,
    output logic             grt_4,
    output logic [DATAW:0]   odata,
    output logic             ovalid,
    output logic [VCHW:0]    ovch,
    input  logic [VCH:0]     irdy,
    output logic [VCH:0]     ordy,
    output logic [VCH:0]     olck
);

    if (PORTID < 0 || PORTID >= int'(NIN) || ROUTERID < 0) begin : g_cfg_check
        $error("outputc: PORTID must be 0..4 and ROUTERID non-negative");
    end

    localparam logic [PORTW:0] MY_PORT = (PORTW+1)'(PORTID);

    logic [DATAW:0]  data_arr [NIN];
    logic [VCHW:0]   vch_arr  [NIN];
    logic [PORTW:0]  port_arr [NIN];
    logic [NIN-1:0]  req_raw;
    logic [NIN-1:0]  ivalid_vec;
    logic [NIN-1:0]  req_vec;
    logic [NIN-1:0]  grt_vec;
    logic [NIN-1:0]  arb_gnt;
    logic [PTRW-1:0] arb_winner;

    state_t          state, state_nxt;
    logic [PTRW-1:0] owner;
    logic [PTRW-1:0] ptr;
    logic [VCHW:0]   ovc;

    logic            accept;
    logic [DATAW:0]  flit_data;
    logic [VCHW:0]   flit_vch;

    assign data_arr   = '{idata_0, idata_1, idata_2, idata_3, idata_4};
    assign vch_arr    = '{ivch_0, ivch_1, ivch_2, ivch_3, ivch_4};
    assign port_arr   = '{port_0, port_1, port_2, port_3, port_4};
    assign req_raw    = {req_4, req_3, req_2, req_1, req_0};
    assign ivalid_vec = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};

    always_comb begin
        req_vec = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            req_vec[i] = req_raw[i] && (port_arr[i] == MY_PORT);
        end
    end

    rrarb u_rrarb (
        .req    (req_vec),
        .ptr    (ptr),
        .gnt    (arb_gnt),
        .winner (arb_winner)
    );

    // Grant and lock are decoded from state so an async reset clears them at once.
    always_comb begin
        state_nxt = state;
        grt_vec   = '0;
        olck      = '0;
        accept    = Disable;
        case (state)
            ST_IDLE: begin
                if (|arb_gnt) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                grt_vec[owner] = irdy[ovc];
                olck[ovc]      = Enable;
                accept         = ivalid_vec[owner] && irdy[ovc];
                if (accept && is_tail(data_arr[owner])) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= ST_IDLE;
            owner <= '0;
            ptr   <= '0;
            ovc   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && (|arb_gnt)) begin
                owner <= arb_winner;
                ptr   <= (arb_winner == PTRW'(NIN - 1)) ? '0 : arb_winner + 3'd1;
                ovc   <= vch_arr[arb_winner];
            end
        end
    end

    assign flit_data = accept ? data_arr[owner] : '0;
    assign flit_vch  = accept ? ovc : '0;

`ifdef OUTC_OREG_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            odata  <= '0;
            ovalid <= 1'b0;
            ovch   <= '0;
        end else begin
            odata  <= flit_data;
            ovalid <= accept;
            ovch   <= flit_vch;
        end
    end
`else
    assign odata  = flit_data;
    assign ovalid = accept;
    assign ovch   = flit_vch;
`endif

    assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grt_vec;
    assign ordy = irdy;

endmodule

// File: tb/tb_outputc.sv
// Directed table-driven bench for outputc (PORTID=2), plus reset-mid-packet sequence.
module tb_outputc;
    import outputc_pkg::*;

    logic        clk;
    logic        rst_;
    logic [4:0]  req;
    logic [2:0]  port  [5];
    logic [31:0] idata [5];
    logic [4:0]  ivalid;
    logic [1:0]  ivch  [5];
    logic [3:0]  irdy;
    logic        g0, g1, g2, g3, g4;
    logic [4:0]  grt;
    logic [31:0] odata;
    logic        ovalid;
    logic [1:0]  ovch;
    logic [3:0]  ordy;
    logic [3:0]  olck;

    int unsigned checks;
    int unsigned failures;

    assign grt = {g4, g3, g2, g1, g0};

    outputc #(.ROUTERID(0), .PORTID(2)) dut (
        .clk(clk), .rst_(rst_),
        .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]), .req_4(req[4]),
        .port_0(port[0]), .port_1(port[1]), .port_2(port[2]), .port_3(port[3]), .port_4(port[4]),
        .idata_0(idata[0]), .idata_1(idata[1]), .idata_2(idata[2]), .idata_3(idata[3]), .idata_4(idata[4]),
        .ivalid_0(ivalid[0]), .ivalid_1(ivalid[1]), .ivalid_2(ivalid[2]), .ivalid_3(ivalid[3]), .ivalid_4(ivalid[4]),
        .ivch_0(ivch[0]), .ivch_1(ivch[1]), .ivch_2(ivch[2]), .ivch_3(ivch[3]), .ivch_4(ivch[4]),
        .grt_0(g0), .grt_1(g1), .grt_2(g2), .grt_3(g3), .grt_4(g4),
        .odata(odata), .ovalid(ovalid), .ovch(ovch),
        .irdy(irdy), .ordy(ordy), .olck(olck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        logic [4:0] pm;
        logic [4:0] vld;
        logic [1:0] ft;
        logic [3:0] irdy;
        logic [4:0] e_grt;
        logic       e_val;
        logic [2:0] e_src;
        logic [3:0] e_lck;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input logic [4:0] rq, input logic [4:0] pm, input logic [4:0] vl,
                                 input logic [1:0] ft, input logic [3:0] rd, input logic [4:0] g,
                                 input logic v, input logic [2:0] src, input logic [3:0] lk);
        vec_t r;
        r.req = rq; r.pm = pm; r.vld = vl; r.ft = ft; r.irdy = rd;
        r.e_grt = g; r.e_val = v; r.e_src = src; r.e_lck = lk;
        return r;
    endfunction

    function automatic logic [31:0] mk(input logic [1:0] ft, input int unsigned seq, input int unsigned src);
        return {ft, 22'(seq), 8'(src)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req = '0; ivalid = '0;
        for (int i = 0; i < 5; i++) begin
            port[i]  = 3'd3;
            idata[i] = '0;
        end
    endtask

    initial begin
        logic [31:0] exp_data, prev_data;
        logic        exp_val, prev_val;
        logic [1:0]  exp_vch, prev_vch;
        string       tag;
        checks = 0; failures = 0;
        prev_data = '0; prev_val = 1'b0; prev_vch = '0;
        rst_ = 1'b0;
        clear_inputs();
        for (int i = 0; i < 5; i++) ivch[i] = 2'(i % 4);
        irdy = 4'b0101;

        // contention 0,1,3 from ptr=0; stray valids from non-owners
        tbl.push_back(mkv(5'b01011, 5'b11111, 5'b00000, TYPE_HEAD,     4'hF, 5'b00000, 0, 0, 4'b0000));
        tbl.push_back(mkv(5'b01011, 5'b11111, 5'b01011, TYPE_HEAD,     4'hF, 5'b00001, 1, 0, 4'b0001));
        tbl.push_back(mkv(5'b01011, 5'b11111, 5'b01011, TYPE_TAIL,     4'hF, 5'b00001, 1, 0, 4'b0001));
        tbl.push_back(mkv(5'b01010, 5'b11111, 5'b00000, TYPE_HEAD,     4'hF, 5'b00000, 0, 0, 4'b0000));
        tbl.push_back(mkv(5'b01010, 5'b11111, 5'b01010, TYPE_HEAD,     4'hF, 5'b00010, 1, 1, 4'b0010));
        tbl.push_back(mkv(5'b01010, 5'b11111, 5'b01010, TYPE_TAIL,     4'hF, 5'b00010, 1, 1, 4'b0010));
        tbl.push_back(mkv(5'b01000, 5'b11111, 5'b00000, TYPE_HEAD,     4'hF, 5'b00000, 0, 0, 4'b0000));
        tbl.push_back(mkv(5'b01000, 5'b11111, 5'b01000, TYPE_HEAD,     4'hF, 5'b01000, 1, 3, 4'b1000));
        tbl.push_back(mkv(5'b01000, 5'b11111, 5'b01000, TYPE_TAIL,     4'hF, 5'b01000, 1, 3, 4'b1000));
        // ptr=4: single-flit packet from input 4, ptr wraps to 0
        tbl.push_back(mkv(5'b10000, 5'b11111, 5'b00000, TYPE_HEADTAIL, 4'hF, 5'b00000, 0, 0, 4'b0000));
        tbl.push_back(mkv(5'b10000, 5'b11111, 5'b10000, TYPE_HEADTAIL, 4'hF, 5'b10000, 1, 4, 4'b0001));
        tbl.push_back(mkv(5'b00000, 5'b11111, 5'b00000, TYPE_HEAD,     4'hF, 5'b00000, 0, 0, 4'b0000));
        // input 2 requests another port: only input 4 is eligible
        tbl.push_back(mkv(5'b10100, 5'b10000, 5'b00000, TYPE_HEAD,     4'hF, 5'b00000, 0, 0, 4'b0000));
        tbl.push_back(mkv(5'b10100, 5'b10000, 5'b10100, TYPE_HEADTAIL, 4'hF, 5'b10000, 1, 4, 4'b0001));
        // ptr=0 tie between 2 and 4 -> 2; backpressure on vc2 mid-packet
        tbl.push_back(mkv(5'b10100, 5'b11111, 5'b00000, TYPE_HEAD,     4'hF, 5'b00000, 0, 0, 4'b0000));
        tbl.push_back(mkv(5'b10100, 5'b11111, 5'b00100, TYPE_HEAD,     4'hF, 5'b00100, 1, 2, 4'b0100));
        tbl.push_back(mkv(5'b10100, 5'b11111, 5'b00100, TYPE_BODY,     4'hB, 5'b00000, 0, 0, 4'b0100));
        tbl.push_back(mkv(5'b10100, 5'b11111, 5'b00100, TYPE_BODY,     4'hB, 5'b00000, 0, 0, 4'b0100));
        tbl.push_back(mkv(5'b10100, 5'b11111, 5'b00100, TYPE_BODY,     4'hF, 5'b00100, 1, 2, 4'b0100));
        tbl.push_back(mkv(5'b10100, 5'b11111, 5'b00100, TYPE_TAIL,     4'h7, 5'b00100, 1, 2, 4'b0100));
        // ptr=3: 2 and 4 request -> 4 wins
        tbl.push_back(mkv(5'b10100, 5'b11111, 5'b00000, TYPE_HEAD,     4'hF, 5'b00000, 0, 0, 4'b0000));
        tbl.push_back(mkv(5'b10100, 5'b11111, 5'b10000, TYPE_HEADTAIL, 4'hF, 5'b10000, 1, 4, 4'b0001));
        // valids while idle are ignored
        tbl.push_back(mkv(5'b00000, 5'b11111, 5'b11111, TYPE_TAIL,     4'hF, 5'b00000, 0, 0, 4'b0000));
        tbl.push_back(mkv(5'b00000, 5'b11111, 5'b00000, TYPE_HEAD,     4'hF, 5'b00000, 0, 0, 4'b0000));

        #12;
        chk("reset_grt",    32'(grt),    32'd0);
        chk("reset_ovalid", 32'(ovalid), 32'd0);
        chk("reset_odata",  odata,       32'd0);
        chk("reset_ovch",   32'(ovch),   32'd0);
        chk("reset_olck",   32'(olck),   32'd0);
        chk("reset_ordy",   32'(ordy),   32'h5);
        irdy = 4'hF;
        @(negedge clk);
        rst_ = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 5; i++) begin
                req[i]    = tbl[k].req[i];
                port[i]   = tbl[k].pm[i] ? 3'd2 : 3'd3;
                ivalid[i] = tbl[k].vld[i];
                idata[i]  = mk(tbl[k].ft, k, i);
            end
            irdy = tbl[k].irdy;
            @(negedge clk);
            exp_val  = tbl[k].e_val;
            exp_data = exp_val ? mk(tbl[k].ft, k, tbl[k].e_src) : 32'd0;
            exp_vch  = exp_val ? tbl[k].e_src[1:0] : 2'd0;
`ifdef OUTC_OREG_EN
            {prev_val, exp_val}   = {exp_val, prev_val};
            {prev_data, exp_data} = {exp_data, prev_data};
            {prev_vch, exp_vch}   = {exp_vch, prev_vch};
`endif
            tag = $sformatf("v%0d", k);
            chk({tag, "_grt"},    32'(grt),    32'(tbl[k].e_grt));
            chk({tag, "_ovalid"}, 32'(ovalid), 32'(exp_val));
            chk({tag, "_odata"},  odata,       exp_data);
            chk({tag, "_ovch"},   32'(ovch),   32'(exp_vch));
            chk({tag, "_olck"},   32'(olck),   32'(tbl[k].e_lck));
            chk({tag, "_ordy"},   32'(ordy),   32'(tbl[k].irdy));
        end

        // reset mid-packet: input 1 owns (ptr=2), async reset clears everything
        @(posedge clk); #1;
        clear_inputs();
        req[1] = 1'b1; port[1] = 3'd2;
        @(posedge clk); #1;
        ivalid[1] = 1'b1; idata[1] = mk(TYPE_HEAD, 99, 1);
        #2;
        chk("rst_pre_grt",  32'(grt),  32'b00010);
        chk("rst_pre_olck", 32'(olck), 32'b0010);
        rst_ = 1'b0;
        #1;
        chk("rst_mid_grt",    32'(grt),    32'd0);
        chk("rst_mid_ovalid", 32'(ovalid), 32'd0);
        chk("rst_mid_odata",  odata,       32'd0);
        chk("rst_mid_ovch",   32'(ovch),   32'd0);
        chk("rst_mid_olck",   32'(olck),   32'd0);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        // ptr must restart at 0: input 1 beats input 3
        @(posedge clk); #1;
        req[1] = 1'b1; port[1] = 3'd2;
        req[3] = 1'b1; port[3] = 3'd2;
        @(negedge clk);
        chk("post_rst_idle_grt", 32'(grt), 32'd0);
        @(negedge clk);
        chk("post_rst_grt",  32'(grt),  32'b00010);
        chk("post_rst_olck", 32'(olck), 32'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
